dtw_stream_core: RTL

Parametrised streaming DTW distance engine, the successor to the fixed-size DC/BT/CTRL top. It loads a TLEN-sample template from external word memory, then consumes a query stream one sample at a time over a valid/ready handshake. It computes one DTW cost-matrix column per accepted sample using a single column buffer, and reports the final accumulated distance D[TLEN-1][last]. Template length, sample width, accumulator width and distance metric are generics; accumulation saturates instead of wrapping.

---
 rtl/dtw_stream_core.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dtw_stream_core.sv
// Streaming DTW distance engine: loads a TLEN-sample template from word memory, then
// computes one saturating cost-matrix column per accepted query sample.

module dtw_stream_core #(
  parameter int unsigned SAMPLE_W  = 8,
  parameter int unsigned TLEN      = 32,
  parameter int unsigned TIDX_W    = 5,
  parameter int unsigned ACC_W     = 16,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DIST_MODE = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  output logic [ADDR_W-1:0]   addr_o,
  output logic                CS_o,
  input  logic [31:0]         data_i,
  input  logic [SAMPLE_W-1:0] Sin_i,
  input  logic                last_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [ACC_W-1:0]    result_o,
  output logic [15:0]         rlen_o,
  output logic                result_valid_o,
  input  logic                result_ack_i,
  output logic                tpl_ok_o
);

  localparam int unsigned CNT_W  = TIDX_W + 1;
  localparam int unsigned SQ_W   = 2 * SAMPLE_W;
  localparam int unsigned EXT_W  = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;
  localparam int unsigned RLEN_W = 16;
  localparam logic [ACC_W-1:0]  ACC_MAX  = '1;
  localparam logic [RLEN_W-1:0] RLEN_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_COL,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                cs_q, cs_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic [ACC_W-1:0]    result_q, result_d;
  logic [RLEN_W-1:0]   rlen_q, rlen_d;
  logic                rvalid_q, rvalid_d;
  logic                tpl_ok_q, tpl_ok_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                last_q, last_d;
  logic [TIDX_W-1:0]   i_q, i_d;
  logic [RLEN_W-1:0]   jcnt_q, jcnt_d;
  logic [ACC_W-1:0]    prev_q, prev_d;
  logic [ACC_W-1:0]    diag_q, diag_d;

  // Template and single column buffer are plain storage, never reset.
  logic [SAMPLE_W-1:0] tpl_q [TLEN];
  logic [ACC_W-1:0]    col_q [TLEN];

  logic [SAMPLE_W-1:0] t_c, diff_c;
  logic [EXT_W-1:0]    cost_ext_c;
  logic [ACC_W-1:0]    cost_c, up_c, pred_c, cell_c;
  logic [ACC_W:0]      sum_c;
  logic                first_col_c;
  logic                tpl_we_c;
  logic [TIDX_W-1:0]   tpl_widx_c;
  logic                hs_c, start_load_c;
  logic [RLEN_W-1:0]   jnext_c;
  logic                data_unused_c;

  // Upper memory word bits carry no template data.
  assign data_unused_c = ^data_i[31:SAMPLE_W];

  // One DTW cell: saturated local cost plus the cheapest allowed predecessor.
  always_comb begin : cell_datapath
    t_c    = tpl_q[i_q];
    up_c   = col_q[i_q];
    diff_c = (t_c >= sample_q) ? (t_c - sample_q) : (sample_q - t_c);
    if (DIST_MODE == 1) begin
      cost_ext_c = EXT_W'(SQ_W'(diff_c) * SQ_W'(diff_c));
    end else begin
      cost_ext_c = EXT_W'(diff_c);
    end
    cost_c      = (cost_ext_c > EXT_W'(ACC_MAX)) ? ACC_MAX : ACC_W'(cost_ext_c);
    first_col_c = (jcnt_q == '0);
    pred_c      = '0;
    if (i_q == '0) begin
      if (!first_col_c) pred_c = up_c;
    end else if (first_col_c) begin
      pred_c = prev_q;
    end else begin
      pred_c = prev_q;
      if (up_c < pred_c)   pred_c = up_c;
      if (diag_q < pred_c) pred_c = diag_q;
    end
    sum_c  = (ACC_W+1)'(cost_c) + (ACC_W+1)'(pred_c);
    cell_c = sum_c[ACC_W] ? ACC_MAX : sum_c[ACC_W-1:0];

    tpl_we_c   = (state_q == S_LOAD) && (cnt_q != '0);
    tpl_widx_c = TIDX_W'(cnt_q - CNT_W'(1));
  end

  // Next-state and registered-output logic.
  always_comb begin : fsm_next
    state_d  = state_q;
    addr_d   = addr_q;
    cs_d     = cs_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    result_d = result_q;
    rlen_d   = rlen_q;
    rvalid_d = rvalid_q;
    tpl_ok_d = tpl_ok_q;
    sample_d = sample_q;
    last_d   = last_q;
    i_d      = i_q;
    jcnt_d   = jcnt_q;
    prev_d   = prev_q;
    diag_d   = diag_q;

    hs_c         = (state_q == S_WAIT) && valid_i && ready_q;
    start_load_c = load_i && ((state_q == S_IDLE) || ((state_q == S_WAIT) && !hs_c));
    jnext_c      = (jcnt_q == RLEN_MAX) ? RLEN_MAX : (jcnt_q + RLEN_W'(1));

    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b0;
      end
      S_LOAD: begin
        // Issue one address per cycle; capture lags issue by one cycle.
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q < CNT_W'(TLEN - 1)) begin
          addr_d = addr_q + ADDR_W'(1);
          cs_d   = 1'b1;
        end else begin
          cs_d = 1'b0;
        end
        if (cnt_q == CNT_W'(TLEN)) begin
          state_d  = S_WAIT;
          tpl_ok_d = 1'b1;
          ready_d  = 1'b1;
        end
      end
      S_WAIT: begin
        if (hs_c) begin
          sample_d = Sin_i;
          last_d   = last_i;
          ready_d  = 1'b0;
          i_d      = '0;
          state_d  = S_COL;
        end
      end
      S_COL: begin
        i_d    = i_q + TIDX_W'(1);
        prev_d = cell_c;
        diag_d = up_c;
        if (i_q == TIDX_W'(TLEN - 1)) begin
          i_d    = '0;
          jcnt_d = jnext_c;
          if (last_q) begin
            state_d  = S_DONE;
            result_d = cell_c;
            rlen_d   = jnext_c;
            rvalid_d = 1'b1;
          end else begin
            state_d = S_WAIT;
            ready_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (result_ack_i) begin
          rvalid_d = 1'b0;
          jcnt_d   = '0;
          ready_d  = 1'b1;
          state_d  = S_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (start_load_c) begin
      state_d  = S_LOAD;
      addr_d   = base_addr_i;
      cs_d     = 1'b1;
      cnt_d    = '0;
      tpl_ok_d = 1'b0;
      ready_d  = 1'b0;
      jcnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin : ctrl_regs
    if (rst_i) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      cs_q     <= 1'b0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      result_q <= '0;
      rlen_q   <= '0;
      rvalid_q <= 1'b0;
      tpl_ok_q <= 1'b0;
      sample_q <= '0;
      last_q   <= 1'b0;
      i_q      <= '0;
      jcnt_q   <= '0;
      prev_q   <= '0;
      diag_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cs_q     <= cs_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      result_q <= result_d;
      rlen_q   <= rlen_d;
      rvalid_q <= rvalid_d;
      tpl_ok_q <= tpl_ok_d;
      sample_q <= sample_d;
      last_q   <= last_d;
      i_q      <= i_d;
      jcnt_q   <= jcnt_d;
      prev_q   <= prev_d;
      diag_q   <= diag_d;
    end
  end

  always_ff @(posedge clk_i) begin : storage
    if (tpl_we_c) tpl_q[tpl_widx_c] <= data_i[SAMPLE_W-1:0];
    if (state_q == S_COL) col_q[i_q] <= cell_c;
  end

  assign addr_o         = addr_q;
  assign CS_o           = cs_q;
  assign ready_o        = ready_q;
  assign result_o       = result_q;
  assign rlen_o         = rlen_q;
  assign result_valid_o = rvalid_q;
  assign tpl_ok_o       = tpl_ok_q;

endmodule
